// File: rtl/arb_pkg.sv
// Shared constants and FSM state encoding for the 8-way round-robin arbiter.
package arb_pkg;
   localparam int N_REQ = 8;
   localparam int IDX_W = 3;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;
endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin pick: first set request bit at or after ptr, wrapping 7->0.
module rr_pick8
   import arb_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   logic [N_REQ-1:0] rot;
   logic [IDX_W-1:0] off;

   // rot[i] is the requester i positions after ptr in search order
   always_comb begin
      for (int i = 0; i < N_REQ; i++)
         rot[i] = req[IDX_W'(ptr + IDX_W'(i))];
   end

   always_comb begin
      off = '0;
      for (int i = N_REQ - 1; i >= 0; i--)
         if (rot[i]) off = IDX_W'(i);
   end

   assign idx = ptr + off;
   assign any = |req;

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter with a per-grant hold limit; all outputs registered.
module rr_arbiter8
   import arb_pkg::*;
#(
   parameter int MAX_HOLD = 16,
   parameter int N_REQ    = arb_pkg::N_REQ
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   input  logic             rel,
   output logic [N_REQ-1:0] gnt,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_vld,
   output logic             timeout
);

   localparam int CW = $clog2(MAX_HOLD);

   state_t           state;
   logic [IDX_W-1:0] ptr;
   logic [CW-1:0]    cnt;
   logic [IDX_W-1:0] pick_idx;
   logic             pick_any;
   logic             holder_req;
   logic             at_limit;
   logic             leave;

   rr_pick8 u_pick (
      .req (req),
      .ptr (ptr),
      .idx (pick_idx),
      .any (pick_any)
   );

   assign holder_req = req[gnt_idx];
   assign at_limit   = (cnt == CW'(MAX_HOLD - 1));
   assign leave      = rel | ~holder_req | at_limit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         ptr     <= '0;
         cnt     <= '0;
         gnt     <= '0;
         gnt_idx <= '0;
         gnt_vld <= 1'b0;
         timeout <= 1'b0;
      end else begin
         timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_any) begin
                  state   <= GRANT;
                  gnt_idx <= pick_idx;
                  gnt     <= N_REQ'(1) << pick_idx;
                  gnt_vld <= 1'b1;
                  cnt     <= '0;
               end
            end
            GRANT: begin
               if (leave) begin
                  state   <= IDLE;
                  gnt     <= '0;
                  gnt_idx <= '0;
                  gnt_vld <= 1'b0;
                  ptr     <= gnt_idx + IDX_W'(1);
                  // a release or dropped request wins over the hold limit
                  timeout <= at_limit & ~rel & holder_req;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed plus randomized bench for rr_arbiter8 against a cycle-level reference model.
module tb_rr_arbiter8;
   localparam int MH = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] req = '0;
   logic       rel = 1'b0;
   logic [7:0] gnt;
   logic [2:0] gnt_idx;
   logic       gnt_vld;
   logic       timeout;

   int checks = 0;
   int errors = 0;

   // reference model: holder, cycles held so far, pointer, timeout flag
   bit m_vld, m_to;
   int m_idx, m_ptr, m_cnt;

   always #5 clk = ~clk;

   rr_arbiter8 #(.MAX_HOLD(MH)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .rel     (rel),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .gnt_vld (gnt_vld),
      .timeout (timeout)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      m_vld = 0; m_to = 0; m_idx = 0; m_ptr = 0; m_cnt = 0;
   endfunction

   function automatic void model_step(input logic [7:0] r, input logic l);
      if (!m_vld) begin
         m_to = 0;
         for (int k = 0; k < 8; k++) begin
            int j;
            j = (m_ptr + k) % 8;
            if (r[j]) begin
               m_vld = 1; m_idx = j; m_cnt = 1;
               break;
            end
         end
      end else if (l || !r[m_idx] || m_cnt == MH) begin
         m_to  = !l && r[m_idx];
         m_ptr = (m_idx + 1) % 8;
         m_vld = 0; m_idx = 0; m_cnt = 0;
      end else begin
         m_cnt++;
         m_to = 0;
      end
   endfunction

   task automatic cmp_all();
      chk("gnt",     32'(gnt),     m_vld ? (32'd1 << m_idx) : 32'd0);
      chk("gnt_idx", 32'(gnt_idx), 32'(m_idx));
      chk("gnt_vld", 32'(gnt_vld), 32'(m_vld));
      chk("timeout", 32'(timeout), 32'(m_to));
   endtask

   // one clock: drive, let the edge pass, advance the model, compare
   task automatic cyc(input logic [7:0] r, input logic l);
      req = r; rel = l;
      @(posedge clk);
      model_step(r, l);
      #1;
      cmp_all();
   endtask

   // reset is raised between edges so the async clear is checked before the next edge
   task automatic do_reset();
      rst = 1'b1; req = '0; rel = 1'b0;
      #1;
      chk("rst_gnt",  32'(gnt), 0);
      chk("rst_vld",  32'(gnt_vld), 0);
      chk("rst_idx",  32'(gnt_idx), 0);
      chk("rst_to",   32'(timeout), 0);
      model_reset();
      @(posedge clk);
      #1;
      cmp_all();
      rst = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int starts[$];
      int idle_run, len, to_cnt, to_at;
      logic prev;
      logic [7:0] r;

      // reset state and single-requester grant/release
      @(posedge clk); #1;
      do_reset();
      cyc(8'h01, 1'b0);
      chk("s1_gnt", 32'(gnt), 32'h01);
      chk("s1_idx", 32'(gnt_idx), 0);
      chk("s1_vld", 32'(gnt_vld), 1);
      cyc(8'h01, 1'b1);
      chk("s1_rel_vld", 32'(gnt_vld), 0);
      cyc(8'h03, 1'b0);
      chk("s1_ptr1", 32'(gnt_idx), 1);

      // full rotation with release in the 2nd grant cycle
      do_reset();
      prev = 1'b0; idle_run = 0;
      for (int n = 0; n < 60 && starts.size() < 9; n++) begin
         cyc(8'hFF, m_vld && m_cnt == 2);
         if (gnt_vld && !prev) begin
            if (starts.size() > 0) chk("rr_gap", idle_run, 1);
            starts.push_back(int'(gnt_idx));
            idle_run = 0;
         end
         if (!gnt_vld) idle_run++;
         prev = gnt_vld;
      end
      chk("rr_len", starts.size(), 9);
      foreach (starts[i]) chk("rr_seq", starts[i], i % 8);

      // wrap checks
      do_reset();
      cyc(8'h80, 1'b0);
      chk("wrap7", 32'(gnt_idx), 7);
      cyc(8'h80, 1'b1);
      cyc(8'h81, 1'b0);
      chk("wrap_p0", 32'(gnt_idx), 0);
      cyc(8'h81, 1'b1);
      cyc(8'h40, 1'b0);
      chk("wrap6", 32'(gnt_idx), 6);
      cyc(8'h40, 1'b1);
      cyc(8'h81, 1'b0);
      chk("wrap_p7", 32'(gnt_idx), 7);

      // hold limit: timeout is a registered pulse alongside the drop of gnt_vld
      do_reset();
      len = 0; to_cnt = 0; to_at = 0;
      for (int n = 1; n <= 18; n++) begin
         cyc(8'h06, 1'b0);
         if (gnt_vld && gnt_idx == 3'd1) len++;
         if (timeout) begin to_cnt++; to_at = n; end
      end
      chk("hold_len", len, 16);
      chk("hold_to_cnt", to_cnt, 1);
      chk("hold_to_at", to_at, 17);
      chk("hold_next", 32'(gnt_idx), 2);
      chk("hold_next_vld", 32'(gnt_vld), 1);

      // release at the limit wins over timeout
      do_reset();
      len = 0; to_cnt = 0;
      for (int n = 0; n < 20; n++) begin
         cyc(8'h02, m_vld && m_cnt == MH);
         if (gnt_vld) len++;
         if (timeout) to_cnt++;
      end
      chk("lim_rel_to", to_cnt, 0);
      chk("lim_rel_len", len >= 16 ? 1 : 0, 1);

      // reset during a grant
      do_reset();
      cyc(8'h20, 1'b0);
      cyc(8'h20, 1'b0);
      chk("rst_mid_idx", 32'(gnt_idx), 5);
      do_reset();
      cyc(8'hFF, 1'b0);
      chk("rst_after", 32'(gnt_idx), 0);
      chk("rst_after_vld", 32'(gnt_vld), 1);

      // randomized traffic against the model
      do_reset();
      r = 8'($urandom);
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 7) == 0) r = 8'($urandom);
         cyc(r, $urandom_range(0, 11) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
